// File: rtl/ddr_burst_arbiter.sv
// Round-robin arbiter granting one client at a time a read or write burst on the
// shared DDR controller port, with a per-burst watchdog and a one-cycle gap between bursts.
module ddr_burst_arbiter #(
    parameter int unsigned DDR_ADDR_WIDTH = 28,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT        = 1024
) (
    input  logic                              mem_clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                cli_req,
    input  logic [NUM_REQ-1:0]                cli_we,
    input  logic [NUM_REQ*DDR_ADDR_WIDTH-1:0] cli_addr,
    input  logic [NUM_REQ*10-1:0]             cli_len,
    output logic [NUM_REQ-1:0]                cli_grant,
    output logic [NUM_REQ-1:0]                cli_done,
    output logic [NUM_REQ-1:0]                cli_err,
    output logic                              rd_burst_req,
    output logic                              wr_burst_req,
    output logic [DDR_ADDR_WIDTH-1:0]         rd_burst_addr,
    output logic [DDR_ADDR_WIDTH-1:0]         wr_burst_addr,
    output logic [9:0]                        rd_burst_len,
    output logic [9:0]                        wr_burst_len,
    input  logic                              rd_burst_finish,
    input  logic                              wr_burst_finish,
    output logic                              busy
);

    localparam int unsigned LEN_W = 10;
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                    state, state_next;
    logic [IDX_W-1:0]          rr_ptr, rr_next;
    logic [IDX_W-1:0]          owner, owner_next;
    logic [WD_W-1:0]           watchdog, wd_next;
    logic                      zero_len, zero_next;
    logic [NUM_REQ-1:0]        grant_next, done_next, err_next;
    logic                      rd_req_next, wr_req_next, busy_next;
    logic [DDR_ADDR_WIDTH-1:0] rd_addr_next, wr_addr_next;
    logic [LEN_W-1:0]          rd_len_next, wr_len_next;

    logic                      found;
    logic [IDX_W-1:0]          pick;
    int unsigned               cand;
    logic                      finish_match;
    logic                      complete;

    logic [DDR_ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [LEN_W-1:0]          len_arr  [NUM_REQ];

    // Unpack the flat per-client buses into arrays indexed by client
    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_unpack
        assign addr_arr[g] = cli_addr[g*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
        assign len_arr[g]  = cli_len[g*LEN_W +: LEN_W];
    end

    // Next-state and next-output logic
    always_comb begin
        state_next   = state;
        rr_next      = rr_ptr;
        owner_next   = owner;
        wd_next      = watchdog;
        zero_next    = zero_len;
        grant_next   = cli_grant;
        done_next    = '0;
        err_next     = '0;
        rd_req_next  = rd_burst_req;
        wr_req_next  = wr_burst_req;
        rd_addr_next = rd_burst_addr;
        wr_addr_next = wr_burst_addr;
        rd_len_next  = rd_burst_len;
        wr_len_next  = wr_burst_len;
        found        = 1'b0;
        pick         = '0;
        cand         = 0;
        complete     = 1'b0;

        // Round-robin search starting at rr_ptr
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = (int'(rr_ptr) + k) % int'(NUM_REQ);
            if (!found && cli_req[IDX_W'(cand)]) begin
                found = 1'b1;
                pick  = IDX_W'(cand);
            end
        end

        finish_match = (rd_burst_req && rd_burst_finish) || (wr_burst_req && wr_burst_finish);

        case (state)
            IDLE: begin
                if (found) begin
                    grant_next       = '0;
                    grant_next[pick] = 1'b1;
                    owner_next       = pick;
                    rr_next          = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + IDX_W'(1);
                    wd_next          = '0;
                    zero_next        = (len_arr[pick] == '0);
                    state_next       = BUSY;
                    if (len_arr[pick] != '0) begin
                        if (cli_we[pick]) begin
                            wr_req_next  = 1'b1;
                            wr_addr_next = addr_arr[pick];
                            wr_len_next  = len_arr[pick];
                        end else begin
                            rd_req_next  = 1'b1;
                            rd_addr_next = addr_arr[pick];
                            rd_len_next  = len_arr[pick];
                        end
                    end
                end
            end
            BUSY: begin
                // A matching finish wins over a simultaneous watchdog expiry
                if (zero_len || finish_match) begin
                    complete = 1'b1;
                end else if (watchdog == WD_W'(TIMEOUT - 1)) begin
                    complete        = 1'b1;
                    err_next[owner] = 1'b1;
                end else begin
                    wd_next = watchdog + WD_W'(1);
                end
                if (complete) begin
                    rd_req_next      = 1'b0;
                    wr_req_next      = 1'b0;
                    grant_next       = '0;
                    done_next[owner] = 1'b1;
                    state_next       = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and output registers
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            watchdog      <= '0;
            zero_len      <= 1'b0;
            cli_grant     <= '0;
            cli_done      <= '0;
            cli_err       <= '0;
            rd_burst_req  <= 1'b0;
            wr_burst_req  <= 1'b0;
            rd_burst_addr <= '0;
            wr_burst_addr <= '0;
            rd_burst_len  <= '0;
            wr_burst_len  <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            rr_ptr        <= rr_next;
            owner         <= owner_next;
            watchdog      <= wd_next;
            zero_len      <= zero_next;
            cli_grant     <= grant_next;
            cli_done      <= done_next;
            cli_err       <= err_next;
            rd_burst_req  <= rd_req_next;
            wr_burst_req  <= wr_req_next;
            rd_burst_addr <= rd_addr_next;
            wr_burst_addr <= wr_addr_next;
            rd_burst_len  <= rd_len_next;
            wr_burst_len  <= wr_len_next;
            busy          <= busy_next;
        end
    end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed bench for ddr_burst_arbiter: expected grants are queued as requests are
// driven and popped when the arbiter grants; inputs driven and outputs sampled on negedge.
module tb_ddr_burst_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned NR = 4;
    localparam int unsigned TO = 16;

    logic              mem_clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     cli_req = '0;
    logic [NR-1:0]     cli_we = '0;
    logic [NR*AW-1:0]  cli_addr = '0;
    logic [NR*10-1:0]  cli_len = '0;
    logic [NR-1:0]     cli_grant, cli_done, cli_err;
    logic              rd_burst_req, wr_burst_req;
    logic [AW-1:0]     rd_burst_addr, wr_burst_addr;
    logic [9:0]        rd_burst_len, wr_burst_len;
    logic              rd_burst_finish = 1'b0;
    logic              wr_burst_finish = 1'b0;
    logic              busy;

    ddr_burst_arbiter #(.DDR_ADDR_WIDTH(AW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .mem_clk(mem_clk), .rst(rst),
        .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr), .cli_len(cli_len),
        .cli_grant(cli_grant), .cli_done(cli_done), .cli_err(cli_err),
        .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish),
        .busy(busy)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct {
        int        client;
        bit        we;
        bit [AW-1:0] addr;
        bit [9:0]  len;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    bit [AW-1:0] last_rd_addr, last_wr_addr;
    bit [9:0]    last_rd_len, last_wr_len;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge mem_clk);
    endtask

    task automatic set_client(input int c, input bit we, input bit [AW-1:0] a, input bit [9:0] l);
        cli_we[c]             = we;
        cli_addr[c*AW +: AW]  = a;
        cli_len[c*10 +: 10]   = l;
        cli_req[c]            = 1'b1;
    endtask

    task automatic push(input int c, input bit we, input bit [AW-1:0] a, input bit [9:0] l);
        exp_t e;
        e.client = c; e.we = we; e.addr = a; e.len = l;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        cli_req         = '0;
        rd_burst_finish = 1'b0;
        wr_burst_finish = 1'b0;
        sb.delete();
        #1;
        chk("rst_grant", cli_grant, 0);
        chk("rst_done", cli_done, 0);
        chk("rst_err", cli_err, 0);
        chk("rst_rd_req", rd_burst_req, 0);
        chk("rst_wr_req", wr_burst_req, 0);
        chk("rst_rd_addr", rd_burst_addr, 0);
        chk("rst_wr_addr", wr_burst_addr, 0);
        chk("rst_rd_len", rd_burst_len, 0);
        chk("rst_wr_len", wr_burst_len, 0);
        chk("rst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b0;
        last_rd_addr = '0; last_wr_addr = '0;
        last_rd_len  = '0; last_wr_len  = '0;
    endtask

    // mode 0: finish after delay, 1: watchdog timeout, 2: finish on the watchdog limit, 3: zero length
    task automatic serve(input bit drop, input int mode, input int delay);
        int   n;
        int   c;
        exp_t e;
        bit   exp_err;
        bit [AW-1:0] saved_addr;
        n = 0;
        exp_err = 1'b0;
        while (cli_grant == '0 && n < 40) begin
            tick();
            n++;
        end
        chk("grant_latency", n, 1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=grant %0h expected=none", cli_grant);
            return;
        end
        e = sb.pop_front();
        c = e.client;
        chk("grant", cli_grant, 64'(1) << c);
        chk("busy_on_grant", busy, 1);
        if (e.len == 0) begin
            chk("zero_rd_req", rd_burst_req, 0);
            chk("zero_wr_req", wr_burst_req, 0);
        end else if (e.we) begin
            last_wr_addr = e.addr; last_wr_len = e.len;
            chk("wr_req", wr_burst_req, 1);
            chk("wr_rd_req", rd_burst_req, 0);
            chk("wr_addr", wr_burst_addr, e.addr);
            chk("wr_len", wr_burst_len, e.len);
            chk("rd_addr_hold", rd_burst_addr, last_rd_addr);
            chk("rd_len_hold", rd_burst_len, last_rd_len);
        end else begin
            last_rd_addr = e.addr; last_rd_len = e.len;
            chk("rd_req", rd_burst_req, 1);
            chk("rd_wr_req", wr_burst_req, 0);
            chk("rd_addr", rd_burst_addr, e.addr);
            chk("rd_len", rd_burst_len, e.len);
            chk("wr_addr_hold", wr_burst_addr, last_wr_addr);
            chk("wr_len_hold", wr_burst_len, last_wr_len);
        end
        case (mode)
            0: begin
                if (delay >= 2) begin
                    tick();
                    saved_addr = cli_addr[c*AW +: AW];
                    cli_addr[c*AW +: AW] = ~saved_addr;
                    if (e.we) rd_burst_finish = 1'b1; else wr_burst_finish = 1'b1;
                    tick();
                    rd_burst_finish = 1'b0;
                    wr_burst_finish = 1'b0;
                    cli_addr[c*AW +: AW] = saved_addr;
                    chk("hold_busy", busy, 1);
                    chk("hold_grant", cli_grant, 64'(1) << c);
                    chk("hold_addr", e.we ? wr_burst_addr : rd_burst_addr, e.addr);
                    chk("hold_req", e.we ? wr_burst_req : rd_burst_req, 1);
                    repeat (delay - 2) tick();
                end else begin
                    repeat (delay) tick();
                end
                if (e.we) wr_burst_finish = 1'b1; else rd_burst_finish = 1'b1;
                tick();
                rd_burst_finish = 1'b0;
                wr_burst_finish = 1'b0;
            end
            1, 2: begin
                repeat (TO - 1) tick();
                chk("wd_req_held", e.we ? wr_burst_req : rd_burst_req, 1);
                chk("wd_no_done", cli_done, 0);
                if (mode == 2) begin
                    if (e.we) wr_burst_finish = 1'b1; else rd_burst_finish = 1'b1;
                end else begin
                    exp_err = 1'b1;
                end
                tick();
                rd_burst_finish = 1'b0;
                wr_burst_finish = 1'b0;
            end
            default: tick();
        endcase
        chk("done", cli_done, 64'(1) << c);
        chk("err", cli_err, exp_err ? (64'(1) << c) : 64'(0));
        chk("end_grant", cli_grant, 0);
        chk("end_rd_req", rd_burst_req, 0);
        chk("end_wr_req", wr_burst_req, 0);
        chk("gap_busy", busy, 1);
        if (drop) cli_req[c] = 1'b0;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_grant", cli_grant, 0);
        chk("idle_done", cli_done, 0);
    endtask

    // Structural invariants checked every cycle outside reset
    always @(negedge mem_clk) begin
        if (!rst) begin
            chk("grant_onehot0", $onehot0(cli_grant), 1);
            chk("rd_wr_exclusive", rd_burst_req & wr_burst_req, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        #2;
        do_reset();
        tick();

        // Single client-0 read
        set_client(0, 1'b0, 28'h0000040, 10'd72);
        push(0, 1'b0, 28'h0000040, 10'd72);
        serve(1'b1, 0, 4);

        // Zero-length burst: no DDR request, done on the next edge
        set_client(2, 1'b0, 28'h0000100, 10'd0);
        push(2, 1'b0, 28'h0000100, 10'd0);
        serve(1'b1, 3, 0);

        // Clients 1 and 3 together from reset; client 1 keeps requesting
        do_reset();
        set_client(1, 1'b0, 28'h0001000, 10'd8);
        set_client(3, 1'b1, 28'h0008008, 10'd16);
        push(1, 1'b0, 28'h0001000, 10'd8);
        push(3, 1'b1, 28'h0008008, 10'd16);
        push(1, 1'b0, 28'h0001000, 10'd8);
        serve(1'b0, 0, 3);
        serve(1'b1, 0, 2);
        serve(1'b1, 0, 2);

        // All four held continuously: order 0,1,2,3,0
        do_reset();
        set_client(0, 1'b0, 28'h0000010, 10'd4);
        set_client(1, 1'b0, 28'h0000020, 10'd5);
        set_client(2, 1'b0, 28'h0000030, 10'd6);
        set_client(3, 1'b1, 28'h0000040, 10'd7);
        push(0, 1'b0, 28'h0000010, 10'd4);
        push(1, 1'b0, 28'h0000020, 10'd5);
        push(2, 1'b0, 28'h0000030, 10'd6);
        push(3, 1'b1, 28'h0000040, 10'd7);
        push(0, 1'b0, 28'h0000010, 10'd4);
        serve(1'b0, 0, 1);
        serve(1'b0, 0, 2);
        serve(1'b0, 0, 1);
        serve(1'b0, 0, 1);
        cli_req[3:1] = '0;
        serve(1'b1, 0, 1);

        // Watchdog expiry on a client-2 read
        set_client(2, 1'b0, 28'h0002000, 10'd32);
        push(2, 1'b0, 28'h0002000, 10'd32);
        serve(1'b1, 1, 0);

        // Finish coincident with the watchdog limit on a client-3 write
        set_client(3, 1'b1, 28'h0003000, 10'd64);
        push(3, 1'b1, 28'h0003000, 10'd64);
        serve(1'b1, 2, 0);

        // Reset in the middle of a client-1 write, then priority restarts at client 0
        set_client(1, 1'b1, 28'h0004000, 10'd20);
        tick();
        chk("pre_rst_grant", cli_grant, 4'b0010);
        chk("pre_rst_wr_req", wr_burst_req, 1);
        tick();
        do_reset();
        set_client(0, 1'b0, 28'h0005000, 10'd10);
        set_client(2, 1'b0, 28'h0006000, 10'd12);
        push(0, 1'b0, 28'h0005000, 10'd10);
        push(2, 1'b0, 28'h0006000, 10'd12);
        serve(1'b1, 0, 2);
        serve(1'b1, 0, 2);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_burst_arbiter.md
DDR_BURST_ARBITER -- requirements
Module: ddr_burst_arbiter

Interface
REQ-001 SHALL have parameter DDR_ADDR_WIDTH, default 28, DDR byte/word address width.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters: 0 ISA read, 1 data read, 2 jump-addr read, 3 data store.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum cycles a granted burst may stay outstanding.
REQ-004 SHALL have ports, one per line: name  direction  width  meaning.
- mem_clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- cli_req  in  NUM_REQ  per-client burst request, level; held until cli_done.
- cli_we  in  NUM_REQ  per-client direction; 1 = write, 0 = read.
- cli_addr  in  NUM_REQ*DDR_ADDR_WIDTH  per-client start address; client i in slice i.
- cli_len  in  NUM_REQ*10  per-client burst length; client i in slice i.
- cli_grant  out  NUM_REQ  one-hot grant; client owns the DDR port while set.
- cli_done  out  NUM_REQ  one-cycle pulse to the owner at burst end.
- cli_err  out  NUM_REQ  one-cycle pulse with cli_done when the burst timed out.
- rd_burst_req  out  1  read request to the DDR controller.
- wr_burst_req  out  1  write request to the DDR controller.
- rd_burst_addr  out  DDR_ADDR_WIDTH  read start address.
- wr_burst_addr  out  DDR_ADDR_WIDTH  write start address.
- rd_burst_len  out  10  read length.
- wr_burst_len  out  10  write length.
- rd_burst_finish  in  1  controller read-burst done.
- wr_burst_finish  in  1  controller write-burst done.
- busy  out  1  high in every state except IDLE.

Function
REQ-005 SHALL implement the states IDLE, BUSY and GAP.
REQ-006 In IDLE, with any cli_req high, SHALL pick a winner by round-robin, starting the search at pointer rr_ptr and wrapping modulo NUM_REQ.
REQ-007 On the same edge as REQ-006 SHALL register: cli_grant one-hot, burst address, burst length, and direction from the winner's slices.
REQ-008 On the same edge SHALL assert rd_burst_req or wr_burst_req per cli_we, and enter BUSY; DDR request latency from cli_req is 1 cycle.
REQ-009 SHALL update rr_ptr to (winner+1) mod NUM_REQ at grant.
REQ-010 In BUSY, SHALL hold the request, address, length and grant stable, regardless of cli_req or cli_addr/cli_len changes.
REQ-011 In BUSY, SHALL ignore a finish of the opposite direction.
REQ-012 In BUSY, on the matching finish, SHALL take the following actions on that edge.
- Deassert the request and clear cli_grant.
- Pulse cli_done[winner] for one cycle.
- Enter GAP.
REQ-013 SHALL run a watchdog counter, cleared at grant and incremented each BUSY cycle.
REQ-014 When the watchdog reaches TIMEOUT-1 without the matching finish, SHALL take the following actions on that edge.
- Deassert the request and clear the grant.
- Pulse cli_done[winner] and cli_err[winner].
- Enter GAP.
REQ-015 If the matching finish and timeout occur on the same cycle, SHALL treat the burst as normal completion, with no cli_err.
REQ-016 A winner with cli_len = 0 SHALL be granted without asserting any DDR request, pulse cli_done on the next edge, and enter GAP.
REQ-017 GAP SHALL last exactly one cycle with no grant and no DDR request, then return to IDLE; requests are not sampled in GAP.
REQ-018 Address/len outputs of the inactive direction SHALL hold their last values.
REQ-019 At most one of rd_burst_req and wr_burst_req SHALL be high in any cycle.

Reset
REQ-020 While rst is high, SHALL force the following reset values.
- state = IDLE, rr_ptr = 0, watchdog = 0.
- cli_grant, cli_done, cli_err = 0.
- rd_burst_req, wr_burst_req = 0; all addr/len outputs = 0.
- busy = 0.
REQ-021 Reset asserted mid-burst SHALL drop the DDR request asynchronously, with no cli_done pulse.

Verification
REQ-022 Client 0 read of addr 0x0000040, len 72: rd_burst_req=1, rd_burst_addr=0x0000040, rd_burst_len=72 one cycle after cli_req; finish -> cli_done[0] pulse, 1 GAP cycle, then IDLE.
REQ-023 Clients 1 and 3 request together from reset: grant 1 first; then client 3 (write, wr_burst_addr=0x0008008, len 16); then client 1 again if still requesting.
REQ-024 All four requests held continuously: grant order 0,1,2,3,0; never two grant bits set.
REQ-025 TIMEOUT=16, client 2 read with no finish: after 16 BUSY cycles, cli_done[2] and cli_err[2] pulse together, and rd_burst_req drops.
REQ-026 Client 3 write, wr_burst_finish and the watchdog limit hit on the same cycle: cli_done[3]=1, cli_err[3]=0.
REQ-027 rst pulsed mid-write: wr_burst_req=0 immediately; after release, a new request is granted in priority order from client 0.
